// File: rtl/spi_pkg.sv
// +-----------------------------------------------------------------------------+
// | spi_pkg : shared state encoding and defaults for the SPI master controller  |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

package spi_pkg;

  localparam int D_PACK_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/spi_clk_gen.sv
// +-----------------------------------------------------------------------------+
// | spi_clk_gen : SCLK divider with phase tick and leading/trailing edge strobes |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_enable,
  input  logic i_toggle_en,
  input  logic i_cpol,
  output logic o_sclk,
  output logic o_tick,
  output logic o_lead_edge,
  output logic o_trail_edge
);

  localparam int               DIV_W      = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] C_DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_sclk;
  logic             w_tick;

  // The tick marks the end of every CLK_DIV-long phase; edges only fire in XFER.
  assign w_tick       = i_enable && (r_div_cnt == C_DIV_LAST);
  assign o_tick       = w_tick;
  assign o_lead_edge  = w_tick && i_toggle_en && (r_sclk == i_cpol);
  assign o_trail_edge = w_tick && i_toggle_en && (r_sclk != i_cpol);
  assign o_sclk       = r_sclk;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else begin
      if (!i_enable || w_tick) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + C_DIV_ONE;
      end

      if (!i_toggle_en) begin
        r_sclk <= i_cpol;
      end else if (w_tick) begin
        r_sclk <= ~r_sclk;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master_ctrl.sv
// +-----------------------------------------------------------------------------+
// | spi_master_ctrl : framed SPI master, START/BUSY/DONE handshake, LSB-first   |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int D_PACK  = D_PACK_DEFAULT,
  parameter int CLK_DIV = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [D_PACK-1:0] DATA_TX,
  input  logic              CPOL,
  input  logic              CPHA,
  output logic              BUSY,
  output logic              DONE,
  output logic [D_PACK-1:0] DATA_RX,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              SS_N
);

  localparam int                EDGE_W      = $clog2(2 * D_PACK) + 1;
  localparam logic [EDGE_W-1:0] C_EDGE_LAST = EDGE_W'(2 * D_PACK - 1);
  localparam logic [EDGE_W-1:0] C_EDGE_ONE  = EDGE_W'(1);

  state_t              r_state;
  logic [D_PACK-1:0]   r_tx;
  logic [D_PACK-1:0]   r_rx;
  logic [D_PACK-1:0]   r_data_rx;
  logic [EDGE_W-1:0]   r_edge_cnt;
  logic                r_cpol;
  logic                r_cpha;
  logic                r_busy;
  logic                r_done;
  logic                r_mosi;
  logic                r_ss_n;

  logic w_accept;
  logic w_cpol;
  logic w_div_en;
  logic w_xfer;
  logic w_tick;
  logic w_lead;
  logic w_trail;
  logic w_sclk;
  logic w_sample;
  logic w_advance;
  logic w_last_edge;

  // SCLK must take the new idle level in the same cycle the frame opens.
  assign w_accept    = (r_state == ST_IDLE) && START;
  assign w_cpol      = w_accept ? CPOL : r_cpol;
  assign w_div_en    = (r_state != ST_IDLE);
  assign w_xfer      = (r_state == ST_XFER);
  assign w_last_edge = w_trail && (r_edge_cnt == C_EDGE_LAST);
  assign w_sample    = r_cpha ? w_trail : w_lead;
  assign w_advance   = r_cpha ? w_lead : (w_trail && !w_last_edge);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .i_enable     (w_div_en),
    .i_toggle_en  (w_xfer),
    .i_cpol       (w_cpol),
    .o_sclk       (w_sclk),
    .o_tick       (w_tick),
    .o_lead_edge  (w_lead),
    .o_trail_edge (w_trail)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_tx       <= '0;
      r_rx       <= '0;
      r_data_rx  <= '0;
      r_edge_cnt <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mosi     <= 1'b0;
      r_ss_n     <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (START) begin
            // CPHA=0 has bit0 on the line already, so its shifter starts at bit1.
            r_tx       <= CPHA ? DATA_TX : {1'b0, DATA_TX[D_PACK-1:1]};
            r_mosi     <= DATA_TX[0];
            r_cpol     <= CPOL;
            r_cpha     <= CPHA;
            r_rx       <= '0;
            r_edge_cnt <= '0;
            r_busy     <= 1'b1;
            r_ss_n     <= 1'b0;
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_lead || w_trail) begin
            r_edge_cnt <= r_edge_cnt + C_EDGE_ONE;
          end
          if (w_sample) begin
            r_rx <= {MISO, r_rx[D_PACK-1:1]};
          end
          if (w_advance) begin
            r_mosi <= r_tx[0];
            r_tx   <= {1'b0, r_tx[D_PACK-1:1]};
          end
          if (w_last_edge) begin
            r_edge_cnt <= '0;
            r_state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_busy    <= 1'b0;
            r_ss_n    <= 1'b1;
            r_done    <= 1'b1;
            r_data_rx <= r_rx;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign DATA_RX = r_data_rx;
  assign SCLK    = w_sclk;
  assign MOSI    = r_mosi;
  assign SS_N    = r_ss_n;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
// +-----------------------------------------------------------------------------+
// | tb_spi_master_ctrl : directed self-checking bench for spi_master_ctrl       |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_spi_master_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        START = 1'b0;
  logic [7:0]  DATA_TX = 8'h00;
  logic        CPOL = 1'b0;
  logic        CPHA = 1'b0;
  logic        BUSY, DONE, SCLK, MOSI, SS_N, MISO;
  logic [7:0]  DATA_RX;

  logic        START2 = 1'b0;
  logic [15:0] DATA_TX2 = 16'h0000;
  logic        CPOL2 = 1'b0;
  logic        CPHA2 = 1'b0;
  logic        BUSY2, DONE2, SCLK2, MOSI2, SS_N2, MISO2;
  logic [15:0] DATA_RX2;

  logic        loop_en = 1'b1;
  logic [7:0]  miso_word = 8'h00;
  int          rise_base = 0;

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          done_cnt = 0;
  int          last_done_cyc = 0;
  int          busy_rise_cyc = 0;
  int          rise_total = 0;
  int          edge_total = 0;
  int          bad_total = 0;
  logic [15:0] mosi_hist = 16'h0000;
  logic        prev_sclk = 1'b0;
  logic        prev_ss_n = 1'b1;
  logic        prev_busy = 1'b0;
  logic        prev_mosi = 1'b0;

  always #5 CLK = ~CLK;

  // Slave model: loopback, or drive bit k of miso_word until the k-th rising SCLK.
  assign MISO  = loop_en ? MOSI : miso_word[3'(rise_total - rise_base)];
  assign MISO2 = MOSI2;

  spi_master_ctrl u_dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .START   (START),
    .DATA_TX (DATA_TX),
    .CPOL    (CPOL),
    .CPHA    (CPHA),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .DATA_RX (DATA_RX),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .SS_N    (SS_N)
  );

  spi_master_ctrl #(
    .D_PACK  (16),
    .CLK_DIV (1)
  ) u_dut16 (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .START   (START2),
    .DATA_TX (DATA_TX2),
    .CPOL    (CPOL2),
    .CPHA    (CPHA2),
    .BUSY    (BUSY2),
    .DONE    (DONE2),
    .DATA_RX (DATA_RX2),
    .SCLK    (SCLK2),
    .MOSI    (MOSI2),
    .MISO    (MISO2),
    .SS_N    (SS_N2)
  );

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (DONE) begin
      done_cnt      = done_cnt + 1;
      last_done_cyc = cyc;
    end
    if (BUSY && !prev_busy) busy_rise_cyc = cyc;
    if (!SS_N && !prev_ss_n && (SCLK != prev_sclk)) begin
      edge_total = edge_total + 1;
      if (SCLK) begin
        rise_total = rise_total + 1;
        mosi_hist  = {MOSI, mosi_hist[15:1]};
        if (MOSI != prev_mosi) bad_total = bad_total + 1;
      end
    end
    prev_sclk = SCLK;
    prev_ss_n = SS_N;
    prev_busy = BUSY;
    prev_mosi = MOSI;
  end

  task automatic start_xfer(input logic [7:0] d, input logic pol, input logic pha,
                            input logic lp, input logic [7:0] mw);
    @(negedge CLK); #1;
    DATA_TX   = d;
    CPOL      = pol;
    CPHA      = pha;
    loop_en   = lp;
    miso_word = mw;
    rise_base = rise_total;
    START     = 1'b1;
    @(posedge CLK); #1;
    START     = 1'b0;
  endtask

  task automatic wait_done(input int base, input string name);
    int n;
    n = 0;
    while (done_cnt == base && n < 300) begin
      @(negedge CLK); #1;
      n++;
    end
    checks++;
    if (done_cnt == base) begin
      errors++;
      $display("FAIL %s: DONE count got %0d exp %0d (timeout)", name, done_cnt, base + 1);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL rst_done: got %b exp 0", DONE); end
    checks++; if (DATA_RX !== 8'h00) begin errors++; $display("FAIL rst_rx: got %h exp 00", DATA_RX); end
    checks++; if (SCLK !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b exp 0", SCLK); end
    checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b exp 0", MOSI); end
    checks++; if (SS_N !== 1'b1) begin errors++; $display("FAIL rst_ss_n: got %b exp 1", SS_N); end
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    checks++; if (SS_N !== 1'b1 || BUSY !== 1'b0) begin
      errors++; $display("FAIL idle_after_rst: ss_n %b busy %b exp 1 0", SS_N, BUSY);
    end
  endtask

  task automatic test_mode0();
    int d0, rb, bb;
    d0 = done_cnt;
    bb = bad_total;
    start_xfer(8'hA5, 1'b0, 1'b0, 1'b1, 8'h00);
    rb = rise_total;
    checks++; if (BUSY !== 1'b1 || SS_N !== 1'b0 || MOSI !== 1'b1 || SCLK !== 1'b0) begin
      errors++; $display("FAIL m0_frame_open: busy %b ss_n %b mosi %b sclk %b exp 1 0 1 0", BUSY, SS_N, MOSI, SCLK);
    end
    wait_done(d0, "m0_done");
    checks++; if (DATA_RX !== 8'hA5) begin errors++; $display("FAIL m0_rx: got %h exp a5", DATA_RX); end
    checks++; if (rise_total - rb != 8) begin errors++; $display("FAIL m0_rises: got %0d exp 8", rise_total - rb); end
    checks++; if (mosi_hist[15:8] !== 8'hA5) begin errors++; $display("FAIL m0_mosi_seq: got %h exp a5", mosi_hist[15:8]); end
    checks++; if (last_done_cyc - busy_rise_cyc != 72) begin
      errors++; $display("FAIL m0_latency: got %0d exp 72", last_done_cyc - busy_rise_cyc);
    end
    checks++; if (SS_N !== 1'b1 || BUSY !== 1'b0) begin
      errors++; $display("FAIL m0_done_cycle: ss_n %b busy %b exp 1 0", SS_N, BUSY);
    end
    checks++; if (bad_total != bb) begin errors++; $display("FAIL m0_mosi_on_rise: got %0d exp 0", bad_total - bb); end
    @(negedge CLK); #1;
    checks++; if (DONE !== 1'b0 || DATA_RX !== 8'hA5) begin
      errors++; $display("FAIL m0_done_pulse: done %b rx %h exp 0 a5", DONE, DATA_RX);
    end
  endtask

  task automatic test_mode3();
    int d0, rb, bb;
    d0 = done_cnt;
    bb = bad_total;
    start_xfer(8'h3C, 1'b1, 1'b1, 1'b0, 8'hC3);
    rb = rise_total;
    checks++; if (SCLK !== 1'b1 || MOSI !== 1'b0) begin
      errors++; $display("FAIL m3_idle_high: sclk %b mosi %b exp 1 0", SCLK, MOSI);
    end
    wait_done(d0, "m3_done");
    checks++; if (DATA_RX !== 8'hC3) begin errors++; $display("FAIL m3_rx: got %h exp c3", DATA_RX); end
    checks++; if (mosi_hist[15:8] !== 8'h3C) begin errors++; $display("FAIL m3_mosi_seq: got %h exp 3c", mosi_hist[15:8]); end
    checks++; if (rise_total - rb != 8) begin errors++; $display("FAIL m3_rises: got %0d exp 8", rise_total - rb); end
    checks++; if (bad_total != bb) begin errors++; $display("FAIL m3_mosi_on_rise: got %0d exp 0", bad_total - bb); end
    checks++; if (SCLK !== 1'b1) begin errors++; $display("FAIL m3_sclk_end: got %b exp 1", SCLK); end
  endtask

  task automatic test_ignore_start();
    int d0;
    d0 = done_cnt;
    start_xfer(8'h96, 1'b0, 1'b0, 1'b1, 8'h00);
    repeat (9) @(negedge CLK);
    #1;
    DATA_TX = 8'hFF;
    CPOL    = 1'b1;
    CPHA    = 1'b1;
    START   = 1'b1;
    @(posedge CLK); #1;
    START   = 1'b0;
    wait_done(d0, "ign_done");
    checks++; if (DATA_RX !== 8'h96) begin errors++; $display("FAIL ign_rx: got %h exp 96", DATA_RX); end
    checks++; if (mosi_hist[15:8] !== 8'h96) begin errors++; $display("FAIL ign_mosi_seq: got %h exp 96", mosi_hist[15:8]); end
    repeat (90) @(negedge CLK);
    #1;
    checks++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL ign_done_count: got %0d exp %0d", done_cnt, d0 + 1); end
    checks++; if (SS_N !== 1'b1 || BUSY !== 1'b0 || SCLK !== 1'b0) begin
      errors++; $display("FAIL ign_idle: ss_n %b busy %b sclk %b exp 1 0 0", SS_N, BUSY, SCLK);
    end
  endtask

  task automatic test_back_to_back();
    int d0, c1;
    d0 = done_cnt;
    @(negedge CLK); #1;
    DATA_TX   = 8'h81;
    CPOL      = 1'b0;
    CPHA      = 1'b0;
    loop_en   = 1'b1;
    rise_base = rise_total;
    START     = 1'b1;
    @(posedge CLK); #1;
    DATA_TX   = 8'h5A;
    wait_done(d0, "b2b_done1");
    c1 = last_done_cyc;
    checks++; if (DATA_RX !== 8'h81) begin errors++; $display("FAIL b2b_rx1: got %h exp 81", DATA_RX); end
    checks++; if (SS_N !== 1'b1) begin errors++; $display("FAIL b2b_gap_high: got %b exp 1", SS_N); end
    @(negedge CLK); #1;
    checks++; if (SS_N !== 1'b0 || BUSY !== 1'b1) begin
      errors++; $display("FAIL b2b_gap_len: ss_n %b busy %b exp 0 1", SS_N, BUSY);
    end
    START = 1'b0;
    wait_done(d0 + 1, "b2b_done2");
    checks++; if (last_done_cyc - c1 != 73) begin errors++; $display("FAIL b2b_spacing: got %0d exp 73", last_done_cyc - c1); end
    checks++; if (DATA_RX !== 8'h5A) begin errors++; $display("FAIL b2b_rx2: got %h exp 5a", DATA_RX); end
    checks++; if (mosi_hist[15:8] !== 8'h5A) begin errors++; $display("FAIL b2b_mosi_seq: got %h exp 5a", mosi_hist[15:8]); end
  endtask

  task automatic test_reset_abort();
    int d0, eb, n;
    d0 = done_cnt;
    start_xfer(8'h33, 1'b0, 1'b0, 1'b1, 8'h00);
    eb = edge_total;
    n  = 0;
    while (edge_total - eb < 7 && n < 300) begin
      @(negedge CLK); #1;
      n++;
    end
    checks++; if (edge_total - eb != 7 || SCLK !== 1'b1) begin
      errors++; $display("FAIL abort_reach_edge7: edges %0d sclk %b exp 7 1", edge_total - eb, SCLK);
    end
    RST_N = 1'b0;
    #1;
    checks++; if (SS_N !== 1'b1 || SCLK !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++; $display("FAIL abort_outputs: ss_n %b sclk %b busy %b done %b exp 1 0 0 0", SS_N, SCLK, BUSY, DONE);
    end
    checks++; if (DATA_RX !== 8'h00) begin errors++; $display("FAIL abort_rx: got %h exp 00", DATA_RX); end
    repeat (2) @(negedge CLK);
    #1;
    RST_N = 1'b1;
    repeat (100) @(negedge CLK);
    #1;
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_no_done: got %0d exp %0d", done_cnt, d0); end
    start_xfer(8'h6C, 1'b0, 1'b0, 1'b1, 8'h00);
    wait_done(d0, "abort_restart_done");
    checks++; if (DATA_RX !== 8'h6C) begin errors++; $display("FAIL abort_restart_rx: got %h exp 6c", DATA_RX); end
  endtask

  task automatic test_clk_div1();
    int   n, busy_n, tog, first_t, last_t;
    logic prev_s, got;
    @(negedge CLK); #1;
    DATA_TX2 = 16'h8001;
    START2   = 1'b1;
    prev_s   = SCLK2;
    n = 0; busy_n = 0; tog = 0; first_t = -1; last_t = -1; got = 1'b0;
    while (!got && n < 200) begin
      @(posedge CLK); #1;
      n++;
      START2 = 1'b0;
      if (BUSY2) busy_n++;
      if (SCLK2 !== prev_s) begin
        tog++;
        if (first_t < 0) first_t = n;
        last_t = n;
      end
      prev_s = SCLK2;
      if (DONE2) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL d1_done: got 0 exp 1 (timeout)"); end
    checks++; if (busy_n != 34) begin errors++; $display("FAIL d1_busy_len: got %0d exp 34", busy_n); end
    checks++; if (tog != 32) begin errors++; $display("FAIL d1_edges: got %0d exp 32", tog); end
    checks++; if (last_t - first_t != 31) begin errors++; $display("FAIL d1_period: span got %0d exp 31", last_t - first_t); end
    checks++; if (DATA_RX2 !== 16'h8001) begin errors++; $display("FAIL d1_rx: got %h exp 8001", DATA_RX2); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_clk_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time got %0t exp below 200000", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
